// File: rtl/noc_credit_injector_if.sv
// Flit link bundle for the credit injector: upstream valid/ready side plus
// router-facing valid/yummy side.
interface noc_credit_injector_if #(
  parameter int DATA_WIDTH = 64
);
  // upstream agent -> injector
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;
  // injector -> router (dataIn_P / validIn_P), router -> injector (yummyOut_P)
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  yummy_in;

  // Injector side
  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output valid_out,
    input  yummy_in
  );

  // Environment side (upstream agent plus router)
  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  valid_out,
    output yummy_in
  );
endinterface

// File: rtl/noc_credit_injector.sv
// Processor-side injection stage: buffers flits from an upstream agent and
// forwards them to a router port under valid/yummy credit flow control.
module noc_credit_injector #(
  parameter int DATA_WIDTH = 64,
  parameter int CREDITS    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset_in,
  noc_credit_injector_if.slave link,
  output logic [CNT_W-1:0]     credits_avail,
  output logic                 credit_err
);

  localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CREDITS_MAX = CNT_W'(CREDITS);
  localparam logic [ADDR_W:0]   PTR_ONE     = (ADDR_W + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0]       wrPtr;
  logic [ADDR_W:0]       rdPtr;
  logic [CNT_W-1:0]      creditCnt;
  logic                  creditErr;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  validOut;

  logic full;
  logic empty;
  logic ready;
  logic push;
  logic send;

  // Occupancy flags, handshake and send decision, all from registered state
  always_comb begin
    full  = (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]) && (wrPtr[ADDR_W] != rdPtr[ADDR_W]);
    empty = (wrPtr == rdPtr);
    ready = ~full;
    push  = link.valid_in & ready;
    send  = ~empty & (creditCnt != '0);
  end

  // FIFO storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr[ADDR_W-1:0]] <= link.data_in;
    end
  end

  // FIFO pointers; push and pop in the same cycle both advance
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (send) rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Output register: one-cycle valid pulse per popped flit, data holds otherwise
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      dataOut  <= '0;
      validOut <= 1'b0;
    end else begin
      validOut <= send;
      if (send) dataOut <= mem[rdPtr[ADDR_W-1:0]];
    end
  end

  // Credit counter with saturation and sticky overflow error
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      creditCnt <= CREDITS_MAX;
      creditErr <= 1'b0;
    end else begin
      unique case ({send, link.yummy_in})
        2'b10: creditCnt <= creditCnt - CNT_W'(1);
        2'b01: begin
          if (creditCnt == CREDITS_MAX) creditErr <= 1'b1;
          else                          creditCnt <= creditCnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign link.ready_out = ready;
  assign link.data_out  = dataOut;
  assign link.valid_out = validOut;
  assign credits_avail  = creditCnt;
  assign credit_err     = creditErr;

endmodule

// File: tb/tb_noc_credit_injector.sv
// Directed self-checking bench for noc_credit_injector.
module tb_noc_credit_injector;

  logic clk = 1'b0;
  logic reset_in;
  logic [2:0] credits_avail;
  logic credit_err;

  int checks = 0;
  int errors = 0;

  noc_credit_injector_if #(.DATA_WIDTH(64)) link ();

  noc_credit_injector #(
    .DATA_WIDTH(64),
    .CREDITS(4),
    .FIFO_DEPTH(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_in(reset_in),
    .link(link),
    .credits_avail(credits_avail),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks valid_out, and data_out only when a flit is expected
  task automatic chkOut(input string tag, input logic v, input logic [63:0] d);
    chk({tag, "_valid"}, link.valid_out, v);
    if (v) chk({tag, "_data"}, link.data_out, d);
  endtask

  initial begin
    int expV[6] = '{0, 1, 1, 1, 1, 0};
    int expC[6] = '{4, 3, 2, 1, 0, 0};

    reset_in      = 1'b1;
    link.valid_in = 1'b0;
    link.data_in  = '0;
    link.yummy_in = 1'b0;

    // 1. Reset
    repeat (3) step();
    reset_in = 1'b0;
    chk("rst_ready",   link.ready_out, 1);
    chk("rst_valid",   link.valid_out, 0);
    chk("rst_data",    link.data_out, 0);
    chk("rst_credits", credits_avail, 4);
    chk("rst_err",     credit_err, 0);

    // 2. Credit limit: flits 1..6, no yummies
    for (int i = 1; i <= 6; i++) begin
      link.valid_in = 1'b1;
      link.data_in  = 64'(i);
      step();
      chkOut($sformatf("lim%0d", i), 1'(expV[i-1]), 64'(i - 1));
      chk($sformatf("lim%0d_credits", i), credits_avail, 64'(expC[i-1]));
    end

    // 3. Fill FIFO with 7, 8, then offer 9 while full
    link.data_in = 64'h7;
    step();
    chk("fill7_ready", link.ready_out, 1);
    chkOut("fill7", 0, 0);
    link.data_in = 64'h8;
    step();
    chk("fill8_ready", link.ready_out, 0);
    link.data_in = 64'h9;
    step();
    chk("full1_ready", link.ready_out, 0);
    chkOut("full1", 0, 0);
    step();
    chk("full2_ready", link.ready_out, 0);
    chk("full2_credits", credits_avail, 0);
    link.valid_in = 1'b0;

    // 4. Credit return: two yummies release 5 then 6
    link.yummy_in = 1'b1;
    step();
    chkOut("ret1", 0, 0);
    chk("ret1_credits", credits_avail, 1);
    step();
    chkOut("ret2", 1, 64'h5);
    chk("ret2_credits", credits_avail, 1);
    link.yummy_in = 1'b0;
    step();
    chkOut("ret3", 1, 64'h6);
    chk("ret3_credits", credits_avail, 0);
    step();
    chkOut("ret4", 0, 0);
    chk("ret4_credits", credits_avail, 0);
    chk("ret4_ready", link.ready_out, 1);

    // 5. Streaming at credits=1 with yummy coincident with each send
    link.yummy_in = 1'b1;
    link.valid_in = 1'b1;
    link.data_in  = 64'hA;
    step();
    chkOut("sim1", 0, 0);
    chk("sim1_credits", credits_avail, 1);
    link.data_in = 64'hB;
    step();
    chkOut("sim2", 1, 64'h7);
    chk("sim2_credits", credits_avail, 1);
    link.data_in = 64'hC;
    step();
    chkOut("sim3", 1, 64'h8);
    chk("sim3_credits", credits_avail, 1);
    link.valid_in = 1'b0;
    step();
    chkOut("sim4", 1, 64'hA);
    step();
    chkOut("sim5", 1, 64'hB);
    chk("sim5_credits", credits_avail, 1);
    link.yummy_in = 1'b0;
    step();
    chkOut("sim6", 1, 64'hC);
    chk("sim6_credits", credits_avail, 0);
    step();
    chkOut("sim7", 0, 0);
    chk("sim7_err", credit_err, 0);

    // 6. Reset with 3 flits buffered, then an overflow yummy
    link.valid_in = 1'b1;
    link.data_in  = 64'hD;
    step();
    link.data_in  = 64'hE;
    step();
    link.data_in  = 64'hF;
    step();
    chkOut("buf3", 0, 0);
    link.valid_in = 1'b0;
    #1;
    reset_in = 1'b1;
    #1;
    chk("mid_rst_credits", credits_avail, 4);
    chk("mid_rst_valid",   link.valid_out, 0);
    chk("mid_rst_data",    link.data_out, 0);
    step();
    reset_in = 1'b0;
    step();
    chkOut("post_rst_empty", 0, 0);
    chk("post_rst_credits", credits_avail, 4);
    chk("post_rst_ready",   link.ready_out, 1);

    link.yummy_in = 1'b1;
    step();
    chk("ovf_err",     credit_err, 1);
    chk("ovf_credits", credits_avail, 4);
    link.yummy_in = 1'b0;
    step();
    chk("ovf_sticky",  credit_err, 1);
    chk("ovf_credits2", credits_avail, 4);

    // Fresh flit after reset is the first to leave
    link.valid_in = 1'b1;
    link.data_in  = 64'h1234_5678_9ABC_DEF0;
    step();
    chkOut("fresh1", 0, 0);
    link.valid_in = 1'b0;
    step();
    chkOut("fresh2", 1, 64'h1234_5678_9ABC_DEF0);
    chk("fresh2_credits", credits_avail, 3);
    step();
    chkOut("fresh3", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
